// File: rtl/axi_slv_wr_responder_pkg.sv
// Shared types for the AXI write-side slave responder: response codes and queue entries.
package axi_slv_pkg;

  localparam int ID_W  = 4;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } aw_entry_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    resp_t           resp;
  } b_entry_t;

endpackage

// File: rtl/axi_slv_wr_responder_if.sv
// AW/W/B channel bundle plus status outputs of the write responder.
interface axi_slv_wr_responder_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32
);
  logic                    in_awvalid;
  logic                    out_awready;
  logic [AXI_ID_W-1:0]     in_awid;
  logic [AXI_ADDR_W-1:0]   in_awaddr;
  logic [7:0]              in_awlen;
  logic                    in_wvalid;
  logic                    out_wready;
  logic [AXI_ID_W-1:0]     in_wid;
  logic [AXI_DATA_W-1:0]   in_wdata;
  logic [AXI_DATA_W/8-1:0] in_wstrb;
  logic                    in_wlast;
  logic                    out_bvalid;
  logic                    in_bready;
  logic [AXI_ID_W-1:0]     out_bid;
  logic [1:0]              out_bresp;
  logic                    out_proto_err;
  logic [15:0]             out_wr_burst_cnt;

  modport slv (
    input  in_awvalid, in_awid, in_awaddr, in_awlen,
    input  in_wvalid, in_wid, in_wdata, in_wstrb, in_wlast, in_bready,
    output out_awready, out_wready, out_bvalid, out_bid, out_bresp,
    output out_proto_err, out_wr_burst_cnt
  );

  modport mst (
    output in_awvalid, in_awid, in_awaddr, in_awlen,
    output in_wvalid, in_wid, in_wdata, in_wstrb, in_wlast, in_bready,
    input  out_awready, out_wready, out_bvalid, out_bid, out_bresp,
    input  out_proto_err, out_wr_burst_cnt
  );
endinterface

// File: rtl/axi_sync_fifo.sv
// Generic synchronous FIFO (power-of-2 depth) with same-cycle push/pop, also when full.
module axi_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int PW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  // a pop frees the slot the push lands in, so a full queue may still accept
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/axi_slv_wr_responder.sv
// AXI write slave responder: queues AW, sinks W against the head burst, returns one B per burst.
// Optional SLV_WID_CHECK_EN: WID mismatch against the head AWID turns the burst into SLVERR.
module axi_slv_wr_responder
  import axi_slv_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_ID_W        = 4,
  parameter int AXI_DATA_W      = 32,
  parameter int SLV_OSTDREQ_NUM = 4,
  parameter int SLV_BRESP_NUM   = 4
) (
  input logic                  aclk,
  input logic                  aresetn,
  axi_slv_wr_responder_if.slv  bus
);
  aw_entry_t   w_aw_in, w_aw_head;
  b_entry_t    w_b_in, w_b_head;
  logic        w_aw_full, w_aw_empty, w_aw_push, w_aw_pop;
  logic        w_b_full, w_b_empty, w_b_push, w_b_pop;
  logic        w_awready, w_wready, w_beat, w_len_hit, w_end, w_err, w_id_err;
  logic        r_rst_done, r_proto_err;
  logic [7:0]  r_beat_cnt;
  logic [15:0] r_burst_cnt;

  // address, data and strobes are accepted but never stored
  logic [AXI_ADDR_W-1:0]   w_unused_addr;
  logic [AXI_DATA_W-1:0]   w_unused_data;
  logic [AXI_DATA_W/8-1:0] w_unused_strb;
  assign w_unused_addr = bus.in_awaddr;
  assign w_unused_data = bus.in_wdata;
  assign w_unused_strb = bus.in_wstrb;

  assign w_awready = r_rst_done && !w_aw_full;
  assign w_wready  = !w_aw_empty && !w_b_full;
  assign w_aw_push = bus.in_awvalid && w_awready;
  assign w_beat    = bus.in_wvalid && w_wready;
  assign w_len_hit = (r_beat_cnt == w_aw_head.len);
  assign w_end     = w_beat && (bus.in_wlast || w_len_hit);
  assign w_aw_pop  = w_end;
  assign w_b_push  = w_end;
  assign w_b_pop   = !w_b_empty && bus.in_bready;
  assign w_err     = (bus.in_wlast != w_len_hit) || w_id_err;
  assign w_aw_in   = '{id: bus.in_awid, len: bus.in_awlen};
  assign w_b_in    = '{id: w_aw_head.id, resp: (w_err ? SLVERR : OKAY)};

`ifdef SLV_WID_CHECK_EN
  logic r_wid_err;
  assign w_id_err = r_wid_err || (bus.in_wid != w_aw_head.id);

  always_ff @(posedge aclk) begin
    if (!aresetn)                r_wid_err <= 1'b0;
    else if (w_end)              r_wid_err <= 1'b0;
    else if (w_beat && w_id_err) r_wid_err <= 1'b1;
  end
`else
  logic [AXI_ID_W-1:0] w_unused_wid;
  assign w_unused_wid = bus.in_wid;
  assign w_id_err     = 1'b0;
`endif

  axi_sync_fifo #(.T(aw_entry_t), .DEPTH(SLV_OSTDREQ_NUM)) u_aw_q (
    .clk(aclk), .rst_n(aresetn),
    .i_push(w_aw_push), .i_data(w_aw_in), .i_pop(w_aw_pop),
    .o_data(w_aw_head), .o_full(w_aw_full), .o_empty(w_aw_empty)
  );

  axi_sync_fifo #(.T(b_entry_t), .DEPTH(SLV_BRESP_NUM)) u_b_q (
    .clk(aclk), .rst_n(aresetn),
    .i_push(w_b_push), .i_data(w_b_in), .i_pop(w_b_pop),
    .o_data(w_b_head), .o_full(w_b_full), .o_empty(w_b_empty)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rst_done  <= 1'b0;
      r_beat_cnt  <= '0;
      r_proto_err <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_end) begin
        r_beat_cnt  <= '0;
        r_burst_cnt <= r_burst_cnt + 16'd1;
        if (w_err) r_proto_err <= 1'b1;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

  // B fields are forced to zero while nothing is queued so reset shows clean outputs
  assign bus.out_awready      = w_awready;
  assign bus.out_wready       = w_wready;
  assign bus.out_bvalid       = !w_b_empty;
  assign bus.out_bid          = w_b_empty ? '0 : w_b_head.id;
  assign bus.out_bresp        = w_b_empty ? 2'b00 : w_b_head.resp;
  assign bus.out_proto_err    = r_proto_err;
  assign bus.out_wr_burst_cnt = r_burst_cnt;
endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic vs a queue model.
module tb_axi_slv_wr_responder;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_slv_wr_responder_if #(.AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32)) bus ();

  axi_slv_wr_responder dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;
  bit rand_bready = 0;
  bit rec_en = 0;
  int popped[$];

  // behavioural model: plain queues of outstanding bursts and responses
  int m_aw_id[$], m_aw_len[$], m_b_id[$], m_b_resp[$];
  int m_beat = 0;
  bit m_wid_bad = 0;
  bit m_rst_done = 0;
  bit m_perr = 0;
  int m_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge aclk) begin
    if (!aresetn) begin
      m_aw_id.delete(); m_aw_len.delete(); m_b_id.delete(); m_b_resp.delete();
      m_beat = 0; m_wid_bad = 0; m_rst_done = 0; m_perr = 0; m_cnt = 0;
    end else begin
      bit awr, wr, bv;
      awr = m_rst_done && (m_aw_id.size() < 4);
      wr  = (m_aw_id.size() > 0) && (m_b_id.size() < 4);
      bv  = (m_b_id.size() > 0);
      if (bv && bus.in_bready) begin
        void'(m_b_id.pop_front());
        void'(m_b_resp.pop_front());
      end
      if (bus.in_wvalid && wr) begin
        bit at_len, bad;
        at_len = (m_beat == m_aw_len[0]);
`ifdef SLV_WID_CHECK_EN
        if (int'(bus.in_wid) != m_aw_id[0]) m_wid_bad = 1;
`endif
        if (bus.in_wlast || at_len) begin
          bad = (bus.in_wlast != at_len) || m_wid_bad;
          m_b_id.push_back(m_aw_id[0]);
          m_b_resp.push_back(bad ? 2 : 0);
          if (bad) m_perr = 1;
          void'(m_aw_id.pop_front());
          void'(m_aw_len.pop_front());
          m_beat = 0;
          m_wid_bad = 0;
          m_cnt = (m_cnt + 1) % 65536;
        end else begin
          m_beat++;
        end
      end
      if (bus.in_awvalid && awr) begin
        m_aw_id.push_back(int'(bus.in_awid));
        m_aw_len.push_back(int'(bus.in_awlen));
      end
      m_rst_done = 1;
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      chk("awready", int'(bus.out_awready), int'(m_rst_done && (m_aw_id.size() < 4)));
      chk("wready", int'(bus.out_wready), int'((m_aw_id.size() > 0) && (m_b_id.size() < 4)));
      chk("bvalid", int'(bus.out_bvalid), int'(m_b_id.size() > 0));
      if (m_b_id.size() > 0) begin
        chk("bid", int'(bus.out_bid), m_b_id[0]);
        chk("bresp", int'(bus.out_bresp), m_b_resp[0]);
      end
      chk("proto_err", int'(bus.out_proto_err), int'(m_perr));
      chk("burst_cnt", int'(bus.out_wr_burst_cnt), m_cnt);
      if (rec_en && bus.out_bvalid && bus.in_bready) popped.push_back(int'(bus.out_bid));
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_bready) bus.in_bready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_inputs();
    bus.in_awvalid = 0; bus.in_awid = '0; bus.in_awaddr = '0; bus.in_awlen = '0;
    bus.in_wvalid = 0; bus.in_wid = '0; bus.in_wdata = '0; bus.in_wstrb = '0;
    bus.in_wlast = 0; bus.in_bready = 0;
  endtask

  task automatic send_aw(input int id, input int len);
    bit hs;
    bit done = 0;
    bus.in_awvalid = 1; bus.in_awid = 4'(id); bus.in_awlen = 8'(len);
    bus.in_awaddr = $urandom;
    for (int i = 0; i < 50 && !done; i++) begin
      hs = bus.out_awready;
      tick();
      done = hs;
    end
    if (!done) chk("aw_timeout", 0, 1);
    bus.in_awvalid = 0;
  endtask

  task automatic send_w(input int id, input bit last);
    bit hs;
    bit done = 0;
    bus.in_wvalid = 1; bus.in_wid = 4'(id); bus.in_wlast = last;
    bus.in_wdata = $urandom; bus.in_wstrb = 4'($urandom);
    for (int i = 0; i < 50 && !done; i++) begin
      hs = bus.out_wready;
      tick();
      done = hs;
    end
    if (!done) chk("w_timeout", 0, 1);
    bus.in_wvalid = 0; bus.in_wlast = 0;
  endtask

  task automatic drain_b();
    bit done = 0;
    rand_bready = 0;
    bus.in_bready = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (!bus.out_bvalid) done = 1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
    bus.in_bready = 0;
  endtask

  initial begin
    idle_inputs();
    aresetn = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_awready", int'(bus.out_awready), 0);
    chk("rst_wready", int'(bus.out_wready), 0);
    chk("rst_bvalid", int'(bus.out_bvalid), 0);
    chk("rst_bid", int'(bus.out_bid), 0);
    chk("rst_cnt", int'(bus.out_wr_burst_cnt), 0);
    chk("rst_perr", int'(bus.out_proto_err), 0);
    aresetn = 1;
    tick();
    chk("awready_after_rst", int'(bus.out_awready), 1);

    // single well-formed burst
    send_aw(5, 3);
    send_w(5, 0); send_w(5, 0); send_w(5, 0);
    chk("single_bvalid_early", int'(bus.out_bvalid), 0);
    send_w(5, 1);
    chk("single_bvalid", int'(bus.out_bvalid), 1);
    chk("single_bid", int'(bus.out_bid), 5);
    chk("single_bresp", int'(bus.out_bresp), 0);
    chk("single_cnt", int'(bus.out_wr_burst_cnt), 1);
    drain_b();

    // early wlast, then a clean burst
    send_aw(6, 7);
    send_w(6, 0); send_w(6, 0); send_w(6, 1);
    chk("early_bid", int'(bus.out_bid), 6);
    chk("early_bresp", int'(bus.out_bresp), 2);
    chk("early_perr", int'(bus.out_proto_err), 1);
    drain_b();
    send_aw(7, 0);
    send_w(7, 1);
    chk("after_err_bresp", int'(bus.out_bresp), 0);
    chk("perr_sticky", int'(bus.out_proto_err), 1);
    drain_b();

    // missing wlast
    send_aw(8, 1);
    send_w(8, 0); send_w(8, 0);
    chk("nolast_bid", int'(bus.out_bid), 8);
    chk("nolast_bresp", int'(bus.out_bresp), 2);
    chk("nolast_wready", int'(bus.out_wready), 0);
    drain_b();

    // fill AW queue, then fill B queue
    bus.in_awvalid = 1; bus.in_awlen = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_awid = 4'(i);
      tick();
    end
    bus.in_awvalid = 0;
    chk("aw_full_awready", int'(bus.out_awready), 0);
    for (int i = 0; i < 4; i++) send_w(i, 1);
    send_aw(9, 0);
    chk("b_full_wready", int'(bus.out_wready), 0);
    bus.in_wvalid = 1; bus.in_wid = 4'd9; bus.in_wlast = 1;
    tick(); tick();
    bus.in_wvalid = 0; bus.in_wlast = 0;
    chk("b_full_cnt", int'(bus.out_wr_burst_cnt), 8);
    drain_b();
    send_w(9, 1);
    drain_b();

    // WID mismatch on first beat
    send_aw(3, 1);
    send_w(2, 0); send_w(3, 1);
`ifdef SLV_WID_CHECK_EN
    chk("wid_bresp", int'(bus.out_bresp), 2);
`else
    chk("wid_bresp", int'(bus.out_bresp), 0);
`endif
    drain_b();

    // ordering under random B backpressure
    send_aw(1, 1); send_aw(2, 0); send_aw(3, 2);
    popped.delete();
    rec_en = 1;
    rand_bready = 1;
    send_w(1, 0); send_w(1, 1); send_w(2, 1);
    send_w(3, 0); send_w(3, 0); send_w(3, 1);
    drain_b();
    tick();
    rec_en = 0;
    chk("order_n", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("order_0", popped[0], 1);
      chk("order_1", popped[1], 2);
      chk("order_2", popped[2], 3);
    end

    // reset in the middle of a burst
    send_aw(4, 3);
    send_w(4, 0); send_w(4, 0);
    aresetn = 0;
    tick();
    chk("midrst_bvalid", int'(bus.out_bvalid), 0);
    chk("midrst_awready", int'(bus.out_awready), 0);
    chk("midrst_wready", int'(bus.out_wready), 0);
    chk("midrst_cnt", int'(bus.out_wr_burst_cnt), 0);
    aresetn = 1;
    tick();
    chk("midrst_awready_back", int'(bus.out_awready), 1);
    chk("midrst_cnt_after", int'(bus.out_wr_burst_cnt), 0);

    // random traffic, model-checked every cycle
    for (int c = 0; c < 600; c++) begin
      bus.in_awvalid = 1'($urandom_range(0, 1));
      bus.in_awid    = 4'($urandom);
      bus.in_awlen   = 8'($urandom_range(0, 3));
      bus.in_awaddr  = $urandom;
      bus.in_wvalid  = ($urandom_range(0, 9) < 6);
      bus.in_wlast   = ($urandom_range(0, 2) == 0);
      bus.in_wdata   = $urandom;
      bus.in_wstrb   = 4'($urandom);
      if (m_aw_id.size() > 0 && $urandom_range(0, 7) != 0) bus.in_wid = 4'(m_aw_id[0]);
      else bus.in_wid = 4'($urandom);
      bus.in_bready  = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
    drain_b();
    tick(); tick();
    chk("final_bvalid", int'(bus.out_bvalid), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
